hash_scorer: RTL and testbench
==============================

# hash_scorer

Downstream of the Threefish/Skein round pipeline. Takes each finished 1024-bit `cyphertext` with its candidate nonce and computes the Hamming distance to the fixed target hash. It keeps the best (lowest) distance seen so far. Every strict improvement is serialized as a short byte frame into the `avr_interface` UART transmit port (`tx_data` / `new_tx_data` / `tx_busy`).

## Interface
Parameters:
- `NONCE_W`, default 32: width of the candidate tag. Must be a multiple of 8.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: a candidate is presented.
- `in_ready`, output, 1: block can accept a candidate. High only in IDLE.
- `cyphertext`, input, 1024: hash output to score.
- `nonce`, input, NONCE_W: tag identifying the candidate.
- `tx_data`, output, 8: byte to the UART.
- `new_tx_data`, output, 1: one-cycle strobe, `tx_data` is valid.
- `tx_busy`, input, 1: UART cannot accept a byte.
- `best_score`, output, 11: lowest distance so far.
- `best_nonce`, output, NONCE_W: nonce that produced `best_score`.

## Operation
- Reset values (applied asynchronously):
  - `best_score` = 11'd2047, so the first candidate always reports.
  - `best_nonce` = 0.
  - `in_ready` = 1.
  - `new_tx_data` = 0.
  - `tx_data` = 8'h00.
  - State = IDLE.
- States: IDLE, COUNT, COMPARE, SEND, GAP.
- IDLE: when `in_valid && in_ready`, the block
  - registers `diff = cyphertext ^ TARGET` and the nonce,
  - clears the accumulator and the slice counter,
  - goes to COUNT.
- COUNT: each cycle, adds the popcount of `diff[64*k +: 64]` to the 11-bit accumulator, for k = 0..15. After k = 15, goes to COMPARE.
  - Accumulator range is 0..1024 and never saturates.
- COMPARE:
  - If `acc < best_score` (strict): updates `best_score`/`best_nonce`, loads the frame, sets byte index to 0, goes to SEND.
  - Otherwise (including equal): returns to IDLE.
- Frame, in order:
  1. SYNC_BYTE 8'hA5.
  2. Nonce bytes, MSB first.
  3. `{5'b0, score[10:8]}`.
  4. `score[7:0]`.
- SEND: while `tx_busy` = 1, waits and holds `new_tx_data` low. When `tx_busy` = 0, it
  - drives `tx_data` with the current byte,
  - pulses `new_tx_data` for exactly one cycle,
  - goes to GAP.
- GAP: one cycle, with no sampling of `tx_busy`. This covers the one-cycle lag before the UART raises `tx_busy`. Then:
  - if more bytes remain, increments the byte index and goes to SEND;
  - after the last byte, goes to IDLE.
- `tx_data` holds its last value when no strobe is active.
- Candidates are never queued. Upstream stalls while `in_ready` = 0.
- Reset during SEND or GAP aborts the frame immediately:
  - no further strobes;
  - `best_*` returns to its reset value.

## Timing
- Accept at cycle 0. COUNT occupies cycles 1–16 and COMPARE is cycle 17.
- Non-improving candidate: `in_ready` is high again at cycle 18. Throughput is 1 candidate per 18 cycles.
- Improving candidate: the first strobe occurs no earlier than cycle 18. Each byte costs at least 2 cycles (SEND + GAP).
- Minimum frame time is 14 cycles for NONCE_W = 32, or 16 with the checksum.
- `best_score` and `best_nonce` update at the clock edge that ends COMPARE, before the frame is sent.

## Configuration
- Macro: `HASH_SCORER_CHECKSUM_EN`.
- Defined: the frame gains one trailing byte, the XOR of all bytes after SYNC (nonce bytes and both score bytes).
- Undefined: the frame ends at `score[7:0]` and no checksum logic is built.

## Structure
- Shared package `skein_pkg` holds:
  - `TARGET` (1024-bit target hash constant);
  - `SYNC_BYTE` = 8'hA5;
  - `SCORE_W` = 11, `SLICE_W` = 64, `NUM_SLICES` = 16;
  - the state enum.
- Sub-module `popcount64`: combinational, 64-bit input, 7-bit count. One instance, muxed by the slice counter.

## Test plan
- `cyphertext = TARGET`, nonce 32'h12345678, `tx_busy` = 0:
  - score 0;
  - frame A5 12 34 56 78 00 00;
  - `best_score` = 0.
- From reset, `cyphertext = ~TARGET`, nonce 32'h00000001:
  - score 1024;
  - frame A5 00 00 00 01 04 00.
- After a score-10 candidate:
  - a score-10 candidate produces no strobe, and `in_ready` returns at cycle 18;
  - a score-9 candidate reports.
- `tx_busy` held high for 50 cycles during SEND:
  - no strobe while held;
  - after release, bytes resume in order;
  - no byte is lost or duplicated.
- Assert `rst` after the 3rd byte strobe:
  - `new_tx_data` drops immediately, with no further bytes;
  - `best_score` = 2047;
  - `in_ready` = 1.
- With `HASH_SCORER_CHECKSUM_EN`, nonce 32'h12345678, score 0:
  - 8th byte = 12^34^56^78^00^00 = 8'h08.

Source files
------------

// File: rtl/skein_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skein_pkg
// Description : Shared constants and types for the Skein candidate scorer:
//               the fixed 1024-bit target hash, the frame sync byte, the
//               score/slice geometry and the scorer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package skein_pkg;

    localparam int SCORE_W    = 11;
    localparam int SLICE_W    = 64;
    localparam int NUM_SLICES = 16;
    localparam int HASH_W     = SLICE_W * NUM_SLICES;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Fixed target hash; slice 15 is the most significant 64-bit word.
    localparam logic [HASH_W-1:0] TARGET = {
        64'h3C6E_F372_FE94_F82B, 64'hA54F_F53A_5F1D_36F1,
        64'h510E_527F_ADE6_82D1, 64'h9B05_688C_2B3E_6C1F,
        64'h1F83_D9AB_FB41_BD6B, 64'h5BE0_CD19_137E_2179,
        64'hCBBB_9D5D_C105_9ED8, 64'h629A_292A_367C_D507,
        64'h9159_015A_3070_DD17, 64'h152F_ECD8_F70E_5939,
        64'h6733_2667_FFC0_0B31, 64'h8EB4_4A87_6858_1511,
        64'hDB0C_2E0D_64F9_8FA7, 64'h47B5_481D_BEFA_4FA4,
        64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210
    };

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/popcount64.sv
`default_nettype none
// ============================================================================
// Module      : popcount64
// Description : Combinational population count of a 64-bit word.
//   i_data  [63:0] : word to count
//   o_count [6:0]  : number of set bits (0..64)
// Revision    : 1.0 - initial release
// ============================================================================
module popcount64 (
    input  logic [63:0] i_data,
    output logic [6:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 64; i++) begin
            o_count = o_count + {6'b0, i_data[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hash_scorer.sv
`default_nettype none
// ============================================================================
// Module      : hash_scorer
// Description : Scores each finished 1024-bit cyphertext by Hamming distance
//               to TARGET, keeps the best (lowest) distance seen, and sends
//               every strict improvement as a byte frame to the UART:
//               SYNC, nonce bytes (MSB first), {5'b0,score[10:8]}, score[7:0]
//               and, with HASH_SCORER_CHECKSUM_EN defined, a trailing XOR of
//               all bytes after SYNC.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : candidate handshake (ready only while idle)
//   cyphertext, nonce   : candidate hash and its tag
//   tx_data, new_tx_data: byte and one-cycle strobe to the UART
//   tx_busy             : UART cannot accept a byte
//   best_score/best_nonce: lowest distance so far and its nonce
// Configuration macro : HASH_SCORER_CHECKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module hash_scorer
    import skein_pkg::*;
#(
    parameter int NONCE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1023:0]       cyphertext,
    input  logic [NONCE_W-1:0]  nonce,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    input  logic                tx_busy,
    output logic [10:0]         best_score,
    output logic [NONCE_W-1:0]  best_nonce
);

    localparam int C_NONCE_BYTES = NONCE_W / 8;
`ifdef HASH_SCORER_CHECKSUM_EN
    localparam int C_NUM_BYTES = C_NONCE_BYTES + 4;
`else
    localparam int C_NUM_BYTES = C_NONCE_BYTES + 3;
`endif
    localparam int C_FRAME_W = 8 * C_NUM_BYTES;
    localparam int C_IDX_W   = $clog2(C_NUM_BYTES);

    localparam logic [C_IDX_W-1:0] C_LAST_IDX   = C_IDX_W'(C_NUM_BYTES - 1);
    localparam logic [3:0]         C_LAST_SLICE = 4'(NUM_SLICES - 1);

    state_t                 r_state;
    logic [HASH_W-1:0]      r_diff;
    logic [NONCE_W-1:0]     r_nonce;
    logic [SCORE_W-1:0]     r_acc;
    logic [3:0]             r_slice;
    logic [C_FRAME_W-1:0]   r_frame;
    logic [C_IDX_W-1:0]     r_byte_idx;

    logic [SLICE_W-1:0]     w_slice;
    logic [6:0]             w_pop;
    logic [C_FRAME_W-1:0]   w_frame;

    // Slice k starts at bit 64*k, i.e. {k, 6'b0}.
    assign w_slice = r_diff[{r_slice, 6'b0} +: SLICE_W];

    popcount64 u_popcount (
        .i_data  (w_slice),
        .o_count (w_pop)
    );

`ifdef HASH_SCORER_CHECKSUM_EN
    logic [7:0] w_cks;

    always_comb begin
        w_cks = {5'b0, r_acc[10:8]} ^ r_acc[7:0];
        for (int i = 0; i < C_NONCE_BYTES; i++) begin
            w_cks = w_cks ^ r_nonce[8*i +: 8];
        end
    end

    assign w_frame = {SYNC_BYTE, r_nonce, 5'b0, r_acc[10:8], r_acc[7:0], w_cks};
`else
    assign w_frame = {SYNC_BYTE, r_nonce, 5'b0, r_acc[10:8], r_acc[7:0]};
`endif

    // The frame is a shift register: the byte on the wire is always the
    // top byte, and GAP shifts the next one into place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_diff      <= '0;
            r_nonce     <= '0;
            r_acc       <= '0;
            r_slice     <= '0;
            r_frame     <= '0;
            r_byte_idx  <= '0;
            in_ready    <= 1'b1;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            best_score  <= 11'd2047;
            best_nonce  <= '0;
        end else begin
            new_tx_data <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_diff   <= cyphertext ^ TARGET;
                        r_nonce  <= nonce;
                        r_acc    <= '0;
                        r_slice  <= '0;
                        in_ready <= 1'b0;
                        r_state  <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_acc   <= r_acc + SCORE_W'(w_pop);
                    r_slice <= r_slice + 4'd1;
                    if (r_slice == C_LAST_SLICE) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (r_acc < best_score) begin
                        best_score <= r_acc;
                        best_nonce <= r_nonce;
                        r_frame    <= w_frame;
                        r_byte_idx <= '0;
                        r_state    <= ST_SEND;
                    end else begin
                        in_ready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= r_frame[C_FRAME_W-1 -: 8];
                        new_tx_data <= 1'b1;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // tx_busy is not looked at here: the UART raises it one
                    // cycle after the strobe.
                    if (r_byte_idx == C_LAST_IDX) begin
                        in_ready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_byte_idx <= r_byte_idx + C_IDX_W'(1);
                        r_frame    <= r_frame << 8;
                        r_state    <= ST_SEND;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hash_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_scorer
// Description : Self-checking bench for hash_scorer. A reference model scores
//               each candidate with $countones, tracks the best score and
//               builds the expected UART frame byte by byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_scorer;
    import skein_pkg::*;

    localparam int NONCE_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1023:0]       cyphertext;
    logic [NONCE_W-1:0]  nonce;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy;
    logic [10:0]         best_score;
    logic [NONCE_W-1:0]  best_nonce;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    bit rand_busy = 1'b0;
    int acc_cyc;
    int idle_cyc;
    int model_best;
    logic [NONCE_W-1:0] model_nonce;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];

    hash_scorer #(.NONCE_W(NONCE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cyphertext  (cyphertext),
        .nonce       (nonce),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .best_score  (best_score),
        .best_nonce  (best_nonce)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART-side monitor: capture every strobed byte, away from the edge.
    always @(posedge clk) begin
        #1;
        if (new_tx_data === 1'b1) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic void build_frame(input logic [NONCE_W-1:0] n, input int s);
        logic [10:0] sc;
`ifdef HASH_SCORER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        sc = s[10:0];
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int b = NONCE_W/8 - 1; b >= 0; b--) begin
            exp_q.push_back(n[8*b +: 8]);
`ifdef HASH_SCORER_CHECKSUM_EN
            x = x ^ n[8*b +: 8];
`endif
        end
        exp_q.push_back({5'b0, sc[10:8]});
        exp_q.push_back(sc[7:0]);
`ifdef HASH_SCORER_CHECKSUM_EN
        x = x ^ {5'b0, sc[10:8]} ^ sc[7:0];
        exp_q.push_back(x);
`endif
    endfunction

    function automatic logic [1023:0] flip_bits(input int nb);
        logic [1023:0] m;
        m = '0;
        for (int i = 0; i < nb; i++) m[$urandom_range(0, 1023)] = 1'b1;
        return TARGET ^ m;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rand_busy) tx_busy = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tx_busy = 1'b0;
        cyphertext = '0;
        nonce = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        model_best = 2047;
        model_nonce = '0;
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        idle_cyc = cyc;
        if (in_ready !== 1'b1) begin
            vectors++;
            errs++;
            $display("FAIL idle_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
    endtask

    task automatic present(input logic [1023:0] ct, input logic [NONCE_W-1:0] n);
        wait_idle();
        in_valid = 1'b1;
        cyphertext = ct;
        nonce = n;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    // Compare captured bytes and best_* against the model for one candidate.
    task automatic check_frame(input logic [1023:0] ct, input logic [NONCE_W-1:0] n);
        int s;
        int bad;
        s = $countones(ct ^ TARGET);
        exp_q.delete();
        if (s < model_best) begin
            build_frame(n, s);
            model_best = s;
            model_nonce = n;
        end
        bad = -1;
        if (rx_q.size() != exp_q.size()) bad = 0;
        else for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            errs++;
            $display("FAIL frame: got %0d bytes (byte[%0d]=%h), required %0d bytes (byte[%0d]=%h), score %0d",
                     rx_q.size(), bad, (rx_q.size() > bad) ? rx_q[bad] : 8'hxx,
                     exp_q.size(), bad, (exp_q.size() > bad) ? exp_q[bad] : 8'hxx, s);
        end
        vectors++;
        if (best_score !== model_best[10:0] || best_nonce !== model_nonce) begin
            errs++;
            $display("FAIL best: score=%0d nonce=%h, required score=%0d nonce=%h",
                     best_score, best_nonce, model_best, model_nonce);
        end
    endtask

    task automatic run_candidate(input logic [1023:0] ct, input logic [NONCE_W-1:0] n);
        rx_q.delete();
        rx_cyc.delete();
        present(ct, n);
        wait_idle();
        check_frame(ct, n);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (in_ready !== 1'b1 || new_tx_data !== 1'b0 || tx_data !== 8'h00 ||
            best_score !== 11'd2047 || best_nonce !== '0) begin
            errs++;
            $display("FAIL reset_state: rdy=%b strb=%b data=%h best=%0d nonce=%h, required 1 0 00 2047 0",
                     in_ready, new_tx_data, tx_data, best_score, best_nonce);
        end
    endtask

    task automatic test_match_target();
        do_reset();
        run_candidate(TARGET, 32'h1234_5678);
        vectors++;
        if (best_score !== 11'd0) begin
            errs++;
            $display("FAIL match_score: best_score=%0d, required 0", best_score);
        end
        vectors++;
        if (rx_cyc.size() == 0 || rx_cyc[0] - acc_cyc < 18) begin
            errs++;
            $display("FAIL first_strobe_latency: got %0d, required >= 18",
                     (rx_cyc.size() > 0) ? rx_cyc[0] - acc_cyc : -1);
        end
        vectors++;
        if (rx_cyc.size() != exp_q.size() || rx_cyc.size() < 2 ||
            rx_cyc[rx_cyc.size()-1] - rx_cyc[0] != 2 * (exp_q.size() - 1)) begin
            errs++;
            $display("FAIL byte_spacing: %0d strobes, required %0d at 2-cycle spacing",
                     rx_cyc.size(), exp_q.size());
        end
`ifdef HASH_SCORER_CHECKSUM_EN
        vectors++;
        if (rx_q.size() < 8 || rx_q[7] !== 8'h08) begin
            errs++;
            $display("FAIL checksum: byte7=%h, required 08", (rx_q.size() >= 8) ? rx_q[7] : 8'hxx);
        end
`endif
    endtask

    task automatic test_inverse();
        do_reset();
        run_candidate(~TARGET, 32'h0000_0001);
        vectors++;
        if (best_score !== 11'd1024 || rx_q.size() < 7 || rx_q[5] !== 8'h04 || rx_q[6] !== 8'h00) begin
            errs++;
            $display("FAIL inverse: best=%0d score_hi=%h, required 1024 04",
                     best_score, (rx_q.size() > 5) ? rx_q[5] : 8'hxx);
        end
    endtask

    task automatic test_tie();
        logic [1023:0] m;
        do_reset();
        m = '0;
        m[9:0] = 10'h3FF;
        run_candidate(TARGET ^ m, 32'hAAAA_0010);
        m = '0;
        m[109:100] = 10'h3FF;
        run_candidate(TARGET ^ m, 32'hBBBB_0010);
        vectors++;
        if (idle_cyc - acc_cyc != 17 || rx_q.size() != 0) begin
            errs++;
            $display("FAIL tie: ready after %0d edges with %0d strobes, required 17 and 0",
                     idle_cyc - acc_cyc, rx_q.size());
        end
        m = '0;
        m[508:500] = 9'h1FF;
        run_candidate(TARGET ^ m, 32'hCCCC_0009);
        vectors++;
        if (best_score !== 11'd9) begin
            errs++;
            $display("FAIL improve_9: best_score=%0d, required 9", best_score);
        end
    endtask

    task automatic test_busy_stall();
        logic [1023:0] ct;
        logic [NONCE_W-1:0] n;
        do_reset();
        ct = flip_bits(5);
        n = $urandom;
        rx_q.delete();
        rx_cyc.delete();
        tx_busy = 1'b1;
        present(ct, n);
        repeat (67) tick();
        vectors++;
        if (rx_q.size() != 0) begin
            errs++;
            $display("FAIL busy_hold: %0d strobes while busy, required 0", rx_q.size());
        end
        tx_busy = 1'b0;
        wait_idle();
        check_frame(ct, n);
    endtask

    task automatic test_reset_mid_frame();
        logic [NONCE_W-1:0] n;
        int t;
        do_reset();
        n = 32'hDEAD_BEEF;
        rx_q.delete();
        present(flip_bits(3), n);
        t = 0;
        while (rx_q.size() < 3 && t < 200) begin
            tick();
            t++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (new_tx_data !== 1'b0 || best_score !== 11'd2047 || best_nonce !== '0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL abort_state: strb=%b best=%0d nonce=%h rdy=%b, required 0 2047 0 1",
                     new_tx_data, best_score, best_nonce, in_ready);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        vectors++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'hDE || rx_q[2] !== 8'hAD) begin
            errs++;
            $display("FAIL abort_bytes: got %0d bytes, required exactly A5 DE AD", rx_q.size());
        end
        model_best = 2047;
        model_nonce = '0;
    endtask

    task automatic test_random();
        logic [1023:0] ct;
        do_reset();
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                ct = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            else
                ct = flip_bits($urandom_range(0, 640 - 15 * i));
            run_candidate(ct, $urandom);
        end
        rand_busy = 1'b0;
        tx_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        tx_busy = 1'b0;
        cyphertext = '0;
        nonce = '0;
        test_reset();
        test_match_target();
        test_inverse();
        test_tie();
        test_busy_stall();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
